// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter: CPU (c) and debug/loader (d) share one 32-bit word memory.
// Define DMEM_ARB_RR_EN for round-robin on simultaneous requests; otherwise c has fixed priority.
module dmem_arbiter #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              c_req,
    input  logic              c_we,
    input  logic [1:0]        c_size,
    input  logic              c_uns,
    input  logic [ADDR_W-1:0] c_addr,
    input  logic [31:0]       c_wdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [1:0]        d_size,
    input  logic              d_uns,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [31:0]       d_wdata,
    output logic              c_gnt,
    output logic              c_rvalid,
    output logic [31:0]       c_rdata,
    output logic              c_err,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [31:0]       d_rdata,
    output logic              d_err,
    output logic              m_en,
    output logic              m_we,
    output logic [ADDR_W-3:0] m_addr,
    output logic [3:0]        m_be,
    output logic [31:0]       m_wdata,
    input  logic [31:0]       m_rdata
);

    typedef enum logic [1:0] {IDLE, RD, ERR} state_t;

    state_t      state, state_nx;
    logic        owner;          // 1 = d owns the pending response
    logic        cap_we;
    logic        cap_uns;
    logic [1:0]  cap_size;
    logic [1:0]  cap_off;
`ifdef DMEM_ARB_RR_EN
    logic        last_d;         // 1 = d was the most recent grant
`endif

    logic              sel_d;
    logic              req_any;
    logic              req_we;
    logic              req_uns;
    logic [1:0]        req_size;
    logic [1:0]        req_off;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              req_legal;
    logic [3:0]        req_be;
    logic [31:0]       req_wdata_sh;
    logic [31:0]       rd_shift;
    logic [31:0]       rd_data;
    logic              resp_valid;
    logic              resp_err;
    logic [31:0]       resp_data;

    always_comb begin
`ifdef DMEM_ARB_RR_EN
        sel_d = d_req & (~c_req | ~last_d);
`else
        sel_d = d_req & ~c_req;
`endif
    end

    assign req_any   = c_req | d_req;
    assign req_we    = sel_d ? d_we    : c_we;
    assign req_uns   = sel_d ? d_uns   : c_uns;
    assign req_size  = sel_d ? d_size  : c_size;
    assign req_addr  = sel_d ? d_addr  : c_addr;
    assign req_wdata = sel_d ? d_wdata : c_wdata;
    assign req_off   = req_addr[1:0];

    // Alignment, byte lanes and lane-shifted store data of the selected request.
    always_comb begin
        unique case (req_size)
            2'b00: begin
                req_legal    = 1'b1;
                req_be       = 4'b0001 << req_off;
                req_wdata_sh = {24'b0, req_wdata[7:0]} << {req_off, 3'b000};
            end
            2'b01: begin
                req_legal    = ~req_off[0];
                req_be       = 4'b0011 << req_off;
                req_wdata_sh = {16'b0, req_wdata[15:0]} << {req_off, 3'b000};
            end
            2'b10: begin
                req_legal    = (req_off == 2'b00);
                req_be       = 4'b1111;
                req_wdata_sh = req_wdata;
            end
            default: begin
                req_legal    = 1'b0;
                req_be       = 4'b0000;
                req_wdata_sh = 32'b0;
            end
        endcase
    end

    // Load return uses the captured attributes, never the live request inputs.
    assign rd_shift = m_rdata >> {cap_off, 3'b000};

    always_comb begin
        unique case (cap_size)
            2'b00:   rd_data = cap_uns ? {24'b0, rd_shift[7:0]}
                                       : {{24{rd_shift[7]}}, rd_shift[7:0]};
            2'b01:   rd_data = cap_uns ? {16'b0, rd_shift[15:0]}
                                       : {{16{rd_shift[15]}}, rd_shift[15:0]};
            default: rd_data = rd_shift;
        endcase
    end

    always_comb begin
        // NOTE: every output gets a default first so no path through the case infers a latch.
        state_nx   = state;
        c_gnt      = 1'b0;
        d_gnt      = 1'b0;
        m_en       = 1'b0;
        m_we       = 1'b0;
        m_addr     = '0;
        m_be       = 4'b0000;
        m_wdata    = 32'b0;
        resp_valid = 1'b0;
        resp_err   = 1'b0;
        resp_data  = 32'b0;
        if (!rst) begin
            unique case (state)
                IDLE: begin
                    if (req_any) begin
                        c_gnt = ~sel_d;
                        d_gnt = sel_d;
                        if (req_legal) begin
                            m_en     = 1'b1;
                            m_we     = req_we;
                            m_addr   = req_addr[ADDR_W-1:2];
                            m_be     = req_be;
                            m_wdata  = req_we ? req_wdata_sh : 32'b0;
                            state_nx = req_we ? IDLE : RD;
                        end else begin
                            state_nx = ERR;
                        end
                    end
                end
                RD: begin
                    resp_valid = 1'b1;
                    resp_data  = rd_data;
                    state_nx   = IDLE;
                end
                ERR: begin
                    resp_err   = 1'b1;
                    resp_valid = ~cap_we;
                    state_nx   = IDLE;
                end
                default: state_nx = IDLE;
            endcase
        end
        c_rvalid = resp_valid & ~owner;
        d_rvalid = resp_valid & owner;
        c_err    = resp_err & ~owner;
        d_err    = resp_err & owner;
        c_rdata  = owner ? 32'b0 : resp_data;
        d_rdata  = owner ? resp_data : 32'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            owner    <= 1'b0;
            cap_we   <= 1'b0;
            cap_uns  <= 1'b0;
            cap_size <= 2'b00;
            cap_off  <= 2'b00;
`ifdef DMEM_ARB_RR_EN
            last_d   <= 1'b1;
`endif
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state <= state_nx;
            if (state == IDLE && req_any) begin
                owner    <= sel_d;
                cap_we   <= req_we;
                cap_uns  <= req_uns;
                cap_size <= req_size;
                cap_off  <= req_off;
`ifdef DMEM_ARB_RR_EN
                last_d   <= sel_d;
`endif
            end
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed vector table, random traffic against a
// byte-level memory model, arbitration and reset-abort sequences.
module tb_dmem_arbiter;

    localparam int ADDR_W = 10;
    localparam int MEM_BYTES = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              rst;
    logic              c_req, c_we, c_uns, d_req, d_we, d_uns;
    logic [1:0]        c_size, d_size;
    logic [ADDR_W-1:0] c_addr, d_addr;
    logic [31:0]       c_wdata, d_wdata;
    logic              c_gnt, c_rvalid, c_err, d_gnt, d_rvalid, d_err;
    logic [31:0]       c_rdata, d_rdata;
    logic              m_en, m_we;
    logic [ADDR_W-3:0] m_addr;
    logic [3:0]        m_be;
    logic [31:0]       m_wdata;
    logic [31:0]       m_rdata = 32'b0;

    int total = 0;
    int bad   = 0;

    logic [7:0] mem_env [MEM_BYTES];   // memory the DUT actually talks to
    logic [7:0] ref_mem [MEM_BYTES];   // expected memory contents

    typedef struct {
        bit         who;
        bit         we;
        logic [1:0] size;
        bit         uns;
        logic [9:0] addr;
        logic [31:0] wdata;
        bit         legal;
        logic [3:0] be;
        logic [31:0] rdata;
    } vec_t;

    vec_t tbl [16];

    dmem_arbiter #(.ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst),
        .c_req(c_req), .c_we(c_we), .c_size(c_size), .c_uns(c_uns), .c_addr(c_addr), .c_wdata(c_wdata),
        .d_req(d_req), .d_we(d_we), .d_size(d_size), .d_uns(d_uns), .d_addr(d_addr), .d_wdata(d_wdata),
        .c_gnt(c_gnt), .c_rvalid(c_rvalid), .c_rdata(c_rdata), .c_err(c_err),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
        .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_be(m_be), .m_wdata(m_wdata),
        .m_rdata(m_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (m_en) begin
            if (m_we) begin
                for (int i = 0; i < 4; i++)
                    if (m_be[i]) mem_env[{m_addr, 2'(i)}] <= m_wdata[8*i +: 8];
            end else begin
                m_rdata <= {mem_env[{m_addr, 2'b11}], mem_env[{m_addr, 2'b10}],
                            mem_env[{m_addr, 2'b01}], mem_env[{m_addr, 2'b00}]};
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit legal_f(logic [1:0] sz, logic [9:0] a);
        if (sz == 2'd0) return 1'b1;
        if (sz == 2'd1) return a[0] == 1'b0;
        if (sz == 2'd2) return a[1:0] == 2'b00;
        return 1'b0;
    endfunction

    function automatic logic [3:0] be_f(logic [1:0] sz, logic [9:0] a);
        logic [3:0] b = 4'b0;
        int n = 1 << sz;
        for (int i = 0; i < n; i++) b[int'(a[1:0]) + i] = 1'b1;
        return b;
    endfunction

    function automatic logic [31:0] load_f(logic [1:0] sz, logic [9:0] a, bit u);
        logic [31:0] v = 32'b0;
        int n = 1 << sz;
        for (int i = 0; i < n; i++) v[8*i +: 8] = ref_mem[int'(a) + i];
        if (!u && n < 4 && v[8*n-1])
            for (int i = n; i < 4; i++) v[8*i +: 8] = 8'hFF;
        return v;
    endfunction

    // One isolated transaction from a single requester, checked cycle by cycle.
    task automatic do_access(input bit who, input bit we, input logic [1:0] size, input bit uns,
                             input logic [9:0] addr, input logic [31:0] wdata,
                             input bit exp_legal, input logic [3:0] exp_be, input logic [31:0] exp_rdata);
        logic [31:0] lane_mask;
        @(negedge clk);
        if (who) begin
            d_req = 1'b1; d_we = we; d_size = size; d_uns = uns; d_addr = addr; d_wdata = wdata;
        end else begin
            c_req = 1'b1; c_we = we; c_size = size; c_uns = uns; c_addr = addr; c_wdata = wdata;
        end
        #1;
        check("gnt", who ? d_gnt : c_gnt, 1);
        check("other_gnt", who ? c_gnt : d_gnt, 0);
        check("idle_rvalid_err", {31'b0, c_rvalid | d_rvalid | c_err | d_err}, 0);
        check("m_en", m_en, exp_legal);
        if (exp_legal) begin
            check("m_we", m_we, we);
            check("m_addr", 32'(m_addr), 32'(addr >> 2));
            check("m_be", m_be, exp_be);
            if (we) begin
                for (int i = 0; i < 4; i++) lane_mask[8*i +: 8] = {8{exp_be[i]}};
                check("m_wdata", m_wdata & lane_mask, (wdata << (8 * int'(addr[1:0]))) & lane_mask);
            end
        end
        @(posedge clk);
        #1;
        c_req = 1'b0;
        d_req = 1'b0;
        if (exp_legal && we)
            for (int i = 0; i < (1 << size); i++) ref_mem[int'(addr) + i] = wdata[8*i +: 8];
        @(negedge clk);
        #1;
        check("rvalid", who ? d_rvalid : c_rvalid, !we);
        check("err", who ? d_err : c_err, !exp_legal);
        check("rdata", who ? d_rdata : c_rdata, (!we && exp_legal) ? exp_rdata : 32'b0);
        check("other_resp", {31'b0, who ? (c_rvalid | c_err) : (d_rvalid | d_err)}, 0);
        check("resp_m_en", m_en, 0);
        @(posedge clk);
        @(negedge clk);
        #1;
        check("resp_one_cycle", {31'b0, (who ? d_rvalid : c_rvalid) | (who ? d_err : c_err)}, 0);
    endtask

    initial begin
        logic        r_who, r_we, r_uns, exp_d, last_d_m, lg;
        logic [1:0]  r_size;
        logic [9:0]  r_addr;
        logic [31:0] r_wdata;

        for (int i = 0; i < MEM_BYTES; i++) begin
            mem_env[i] = 8'h00;
            ref_mem[i] = 8'h00;
        end

        tbl[0]  = '{1'b0, 1'b1, 2'd2, 1'b0, 10'h010, 32'h0F0F0F0D, 1'b1, 4'b1111, 32'h0};
        tbl[1]  = '{1'b0, 1'b0, 2'd2, 1'b0, 10'h010, 32'h0,        1'b1, 4'b1111, 32'h0F0F0F0D};
        tbl[2]  = '{1'b0, 1'b1, 2'd1, 1'b0, 10'h014, 32'h0000FFFE, 1'b1, 4'b0011, 32'h0};
        tbl[3]  = '{1'b0, 1'b0, 2'd1, 1'b0, 10'h014, 32'h0,        1'b1, 4'b0011, 32'hFFFFFFFE};
        tbl[4]  = '{1'b0, 1'b0, 2'd1, 1'b1, 10'h014, 32'h0,        1'b1, 4'b0011, 32'h0000FFFE};
        tbl[5]  = '{1'b0, 1'b1, 2'd0, 1'b0, 10'h016, 32'h00000001, 1'b1, 4'b0100, 32'h0};
        tbl[6]  = '{1'b0, 1'b0, 2'd0, 1'b0, 10'h016, 32'h0,        1'b1, 4'b0100, 32'h00000001};
        tbl[7]  = '{1'b0, 1'b0, 2'd2, 1'b0, 10'h012, 32'h0,        1'b0, 4'b0000, 32'h0};
        tbl[8]  = '{1'b0, 1'b1, 2'd1, 1'b0, 10'h013, 32'h00001234, 1'b0, 4'b0000, 32'h0};
        tbl[9]  = '{1'b0, 1'b0, 2'd3, 1'b0, 10'h010, 32'h0,        1'b0, 4'b0000, 32'h0};
        tbl[10] = '{1'b1, 1'b0, 2'd2, 1'b0, 10'h010, 32'h0,        1'b1, 4'b1111, 32'h0F0F0F0D};
        tbl[11] = '{1'b1, 1'b0, 2'd0, 1'b0, 10'h014, 32'h0,        1'b1, 4'b0001, 32'hFFFFFFFE};
        tbl[12] = '{1'b1, 1'b0, 2'd2, 1'b1, 10'h014, 32'h0,        1'b1, 4'b1111, 32'h0001FFFE};
        tbl[13] = '{1'b1, 1'b1, 2'd0, 1'b0, 10'h017, 32'hAAAAAA80, 1'b1, 4'b1000, 32'h0};
        tbl[14] = '{1'b1, 1'b0, 2'd0, 1'b0, 10'h017, 32'h0,        1'b1, 4'b1000, 32'hFFFFFF80};
        tbl[15] = '{1'b0, 1'b0, 2'd1, 1'b1, 10'h016, 32'h0,        1'b1, 4'b1100, 32'h00008001};

        rst = 1'b1;
        c_req = 1'b1; c_we = 1'b0; c_size = 2'd2; c_uns = 1'b0; c_addr = '0; c_wdata = '0;
        d_req = 1'b1; d_we = 1'b1; d_size = 2'd2; d_uns = 1'b0; d_addr = '0; d_wdata = '0;
        #12;
        check("rst_gnt", {30'b0, c_gnt, d_gnt}, 0);
        check("rst_m", {26'b0, m_en, m_we, m_be}, 0);
        check("rst_m_addr_wdata", m_wdata | 32'(m_addr), 0);
        check("rst_resp", {28'b0, c_rvalid, c_err, d_rvalid, d_err}, 0);
        check("rst_rdata", c_rdata | d_rdata, 0);
        c_req = 1'b0;
        d_req = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;

        for (int i = 0; i < 16; i++)
            do_access(tbl[i].who, tbl[i].we, tbl[i].size, tbl[i].uns, tbl[i].addr, tbl[i].wdata,
                      tbl[i].legal, tbl[i].be, tbl[i].rdata);

        for (int i = 0; i < 200; i++) begin
            r_who   = 1'($urandom_range(0, 1));
            r_we    = 1'($urandom_range(0, 1));
            r_uns   = 1'($urandom_range(0, 1));
            r_size  = ($urandom_range(0, 7) == 7) ? 2'd3 : 2'($urandom_range(0, 2));
            r_addr  = 10'($urandom_range(0, 63));
            r_wdata = $urandom;
            lg      = legal_f(r_size, r_addr);
            do_access(r_who, r_we, r_size, r_uns, r_addr, r_wdata, lg,
                      lg ? be_f(r_size, r_addr) : 4'b0,
                      (lg && !r_we) ? load_f(r_size, r_addr, r_uns) : 32'b0);
        end

        // Simultaneous stores held for four cycles, starting from a fresh reset.
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        last_d_m = 1'b1;
        c_req = 1'b1; c_we = 1'b1; c_size = 2'd2; c_addr = 10'h100; c_wdata = 32'h11111111;
        d_req = 1'b1; d_we = 1'b1; d_size = 2'd2; d_addr = 10'h104; d_wdata = 32'h22222222;
        for (int k = 0; k < 4; k++) begin
`ifdef DMEM_ARB_RR_EN
            exp_d = !last_d_m;
`else
            exp_d = 1'b0;
`endif
            last_d_m = exp_d;
            #1;
            check("arb_c_gnt", c_gnt, !exp_d);
            check("arb_d_gnt", d_gnt, exp_d);
            check("arb_m_addr", 32'(m_addr), exp_d ? 32'h41 : 32'h40);
            check("arb_m_en_be", {27'b0, m_en, m_be}, 32'h1F);
            for (int j = 0; j < 4; j++) begin
                if (exp_d) ref_mem[10'h104 + j] = 8'h22;
                else       ref_mem[10'h100 + j] = 8'h11;
            end
            @(negedge clk);
        end
        c_req = 1'b0;
        d_req = 1'b0;

        // Reset landing in the load-return cycle must swallow the response.
        @(negedge clk);
        c_req = 1'b1; c_we = 1'b0; c_size = 2'd2; c_uns = 1'b0; c_addr = 10'h100;
        #1 check("rd_abort_gnt", c_gnt, 1);
        @(posedge clk);
        #1;
        c_req = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        #1;
        check("rd_abort_rvalid", {31'b0, c_rvalid | d_rvalid | c_err | d_err}, 0);
        check("rd_abort_rdata", c_rdata | d_rdata, 0);
        check("rd_abort_m", {26'b0, m_en, m_we, m_be}, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        do_access(1'b0, 1'b0, 2'd2, 1'b0, 10'h100, 32'h0, 1'b1, 4'b1111, load_f(2'd2, 10'h100, 1'b0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
